// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for three requesters sharing one datapath.
// Grants are held for a burst and handed off with no idle cycle in between.
module bus_rr_arbiter #(
   parameter  int MAX_BEATS = 16,
   localparam int CW        = $clog2(MAX_BEATS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    req_i,
   input  logic [2:0]    last_i,
   input  logic          xfer_i,
   output logic [2:0]    gnt_o,
   output logic [1:0]    sel_o,
   output logic          busy_o,
   output logic [CW-1:0] beat_cnt_o
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_OWN  = 1'b1
   } state_t;

   localparam logic [CW-1:0] CNT_CAP = CW'(MAX_BEATS - 1);

   state_t        state_q;
   logic [1:0]    ptr_q;
   logic [1:0]    sel_q;
   logic [2:0]    gnt_q;
   logic [CW-1:0] cnt_q;

   function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
      logic [2:0] oh;
      case (idx)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         default: oh = 3'b100;
      endcase
      return oh;
   endfunction

   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   // Returns {found, index}; scans p+1, p+2, p+3 modulo 3.
   function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
      logic [1:0] c0;
      logic [1:0] c1;
      logic [1:0] c2;
      logic [2:0] res;
      c0  = next_idx(p);
      c1  = next_idx(c0);
      c2  = next_idx(c1);
      res = {1'b0, 2'd0};
      if ((r & idx_to_onehot(c0)) != 3'b000) begin
         res = {1'b1, c0};
      end else if ((r & idx_to_onehot(c1)) != 3'b000) begin
         res = {1'b1, c1};
      end else if ((r & idx_to_onehot(c2)) != 3'b000) begin
         res = {1'b1, c2};
      end
      return res;
   endfunction

   logic [2:0] own_mask;
   logic       own_req;
   logic       own_last;
   logic       cap_hit;
   logic       release_now;
   logic [2:0] masked_req;
   logic [2:0] idle_pick;
   logic [2:0] rel_pick;

   always_comb begin
      own_mask    = idx_to_onehot(sel_q);
      own_req     = |(req_i & own_mask);
      own_last    = |(last_i & own_mask);
      cap_hit     = (cnt_q == CNT_CAP);
      release_now = (xfer_i && own_last) || (xfer_i && cap_hit) || !own_req;
      // The owner is excluded from the handoff pick; on abandon its bit is already low.
      masked_req  = req_i & ~own_mask;
      idle_pick   = rr_pick(req_i, ptr_q);
      rel_pick    = rr_pick(masked_req, sel_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= 2'd2;
         sel_q   <= 2'd0;
         gnt_q   <= 3'b000;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (idle_pick[2]) begin
                  state_q <= S_OWN;
                  ptr_q   <= idle_pick[1:0];
                  sel_q   <= idle_pick[1:0];
                  gnt_q   <= idx_to_onehot(idle_pick[1:0]);
                  cnt_q   <= '0;
               end
            end
            S_OWN: begin
               if (release_now) begin
                  cnt_q <= '0;
                  if (rel_pick[2]) begin
                     ptr_q <= rel_pick[1:0];
                     sel_q <= rel_pick[1:0];
                     gnt_q <= idx_to_onehot(rel_pick[1:0]);
                  end else begin
                     state_q <= S_IDLE;
                     gnt_q   <= 3'b000;
                  end
               end else if (xfer_i) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               gnt_q   <= 3'b000;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign gnt_o      = gnt_q;
   assign sel_o      = sel_q;
   assign busy_o     = |gnt_q;
   assign beat_cnt_o = cnt_q;

endmodule
